alu_seq8: RTL and testbench
===========================

Name: alu_seq8

Overview:
- Initiator-side controller for the 4-bit combinational `alu` (ports A, B, c_in, Op, R, zero, carry, sign).
- Accepts one wide command per handshake and runs it as a sequence of nibble passes through a single external `alu` instance, chaining carry through c_in.
- Returns a wide result with flags through a valid/ready handshake.
- Sits between the command source and the ALU, reusing the existing 3-bit ALU opcode set.

Parameters:
- NIBBLES, 2, number of 4-bit nibbles per operand; data width W = 4*NIBBLES.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block idle, command accepted on valid&ready
- cmd_op  in  3  ALU opcode: 000 A+c, 001 -A+c, 010 A+B+c, 011 A+1+c, 100 AND, 101 OR, 110 XOR, 111 NOT A
- cmd_a  in  W  operand A
- cmd_b  in  W  operand B
- cmd_cin  in  1  carry-in (arithmetic ops only)
- alu_A  out  4  nibble operand to ALU A
- alu_B  out  4  nibble operand to ALU B
- alu_c_in  out  1  to ALU c_in
- alu_Op  out  3  to ALU Op
- alu_R  in  4  ALU result
- alu_zero  in  1  ALU zero flag (unused, R zero test done over full width)
- alu_carry  in  1  ALU carry
- alu_sign  in  1  ALU sign
- res_valid  out  1  result present
- res_ready  in  1  result consumed on valid&ready
- res_r  out  W  result
- res_zero  out  1  res_r == 0
- res_carry  out  1  final carry-out
- res_sign  out  1  res_r[W-1]

Behaviour:
- Clocking and reset:
  - One clock, clk.
  - reset is synchronous, active-high.
  - All outputs are registered.
  - Reset values: cmd_ready=1, res_valid=0, res_r=0, all flags 0, alu_A/alu_B/alu_Op/alu_c_in=0.
- FSM states:
  - IDLE: cmd_ready=1. On cmd_valid, latch operands, set nibble index i=0, go to RUN.
  - RUN: one ALU pass per cycle. alu_* are registered and the ALU output is sampled at the next edge.
  - DONE: res_valid=1 and results held stable until res_ready, then go to IDLE.
  - cmd_ready=0 in RUN and DONE. A command cannot be accepted in the same cycle as the result handshake.
- Carry chaining: link carry k starts as cmd_cin and is updated from alu_carry after each arithmetic pass.
- Per-nibble pass mapping (nibble i):
  - 000: Op 000, c_in=k.
  - 010: Op 010, c_in=k.
  - 011: nibble 0 uses Op 011 with c_in=cmd_cin; higher nibbles use Op 000 with c_in=k.
  - 001: two passes per nibble:
    - (a) Op 111 on A_i, capture the result as t;
    - (b) nibble 0 uses Op 011 on t with c_in=cmd_cin; higher nibbles use Op 000 on t with c_in=k.
    - The ALU's own 001 code is never issued.
  - 100-111: same Op on every nibble, c_in=0, k ignored.
- Latency: NIBBLES passes, or 2*NIBBLES passes for 001. If accepted at edge T, res_valid rises at T+passes+1 (default: T+3, negate T+5).
- Flags:
  - res_carry = alu_carry of the last pass for ops 000-011; 0 for logical ops.
  - res_zero is computed over the full W-bit res_r.
  - res_sign = res_r[W-1].
- Wrap-around: W-bit results wrap modulo 2^W; the carry-out reports the wrap.
- Reset mid-operation: the command is discarded and the block returns to IDLE the next cycle with reset values.
- alu_* hold their last values in IDLE and DONE.

Optional Feature:
- Macro ALU_SEQ_OVF_EN.
- When defined, adds output res_ovf (1 bit), registered with the result and reset to 0. Signed overflow rules:
  - 010: a[W-1]==b[W-1] && r[W-1]!=a[W-1].
  - 000/011: !a[W-1] && r[W-1].
  - 001: a[W-1] && r[W-1].
  - Logical ops: 0.
- When undefined, the port and its logic are absent.

Decomposition:
- Package alu_seq_pkg holds:
  - opcode localparams (OP_PASS, OP_NEG, OP_ADD, OP_INC, OP_AND, OP_OR, OP_XOR, OP_NOT);
  - FSM state encoding;
  - the nibble width constant 4.
- One combinational sub-module, alu_seq_opmap: maps (cmd_op, nibble index, phase, k) to (alu_Op, alu_c_in, operand select).

Test Plan:
- ADD: op=010, a=8'h3C, b=8'h4F, cin=0 -> res_r=8'h8B, carry=0, sign=1, zero=0, ovf=1. res_valid 3 cycles after accept.
- INC wrap: op=011, a=8'hFF, cin=0 -> res_r=8'h00, zero=1, carry=1, sign=0.
- NEG, in two cases, each with res_valid 5 cycles after accept:
  - a=8'h03, cin=0 -> res_r=8'hFD, carry=0, sign=1;
  - a=8'h00 -> res_r=8'h00, zero=1, carry=1.
- Logical ops with carry-in ignored (cin=1):
  - op=100, a=8'hA5, b=8'h3C -> 8'h24, carry=0;
  - op=111, a=8'hA5 -> 8'h5A, sign=0.
- Backpressure: hold res_ready=0 for 3 cycles -> res_r and flags stable, cmd_ready=0. Assert res_ready -> cmd_ready=1 on the following cycle. A pulsed cmd_valid during DONE is not accepted.
- Reset mid-RUN on a negate -> next cycle cmd_ready=1, res_valid=0, alu_Op=0. A new ADD (8'h01+8'h01) then yields 8'h02.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared constants for the nibble-serial ALU sequencer.
// Holds the 4-bit ALU opcode set, the sequencer FSM encoding, the nibble
// width and a helper that classifies opcodes as arithmetic.
package alu_seq_pkg;

    localparam int unsigned NIB_W = 4;

    localparam logic [2:0] OP_PASS = 3'b000;
    localparam logic [2:0] OP_NEG  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_INC  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_XOR  = 3'b110;
    localparam logic [2:0] OP_NOT  = 3'b111;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Opcodes 000-011 chain carry; 100-111 are bitwise
    function automatic logic is_arith(input logic [2:0] op);
        return ~op[2];
    endfunction

endpackage

// File: rtl/alu_seq_opmap.sv
// alu_seq_opmap: per-pass command decode for the sequencer.
// Ports: i_op (command opcode), i_nib (nibble index), i_phase_a (first pass
// of a negate nibble), i_k (link carry), i_cin (command carry-in);
// o_alu_op / o_c_in (values for the ALU), o_sel_t (use the previous ALU
// result instead of the A nibble as operand).
module alu_seq_opmap
    import alu_seq_pkg::*;
#(
    parameter int unsigned IDX_W = 1
) (
    input  logic [2:0]       i_op,
    input  logic [IDX_W-1:0] i_nib,
    input  logic             i_phase_a,
    input  logic             i_k,
    input  logic             i_cin,
    output logic [2:0]       o_alu_op,
    output logic             o_c_in,
    output logic             o_sel_t
);

    logic w_first;
    assign w_first = (i_nib == '0);

    // Negate is ~A then +1 on the low nibble; the ALU's own 001 is never used
    always_comb begin
        o_alu_op = i_op;
        o_c_in   = 1'b0;
        o_sel_t  = 1'b0;
        case (i_op)
            OP_PASS, OP_ADD: o_c_in = i_k;
            OP_INC: begin
                o_alu_op = w_first ? OP_INC : OP_PASS;
                o_c_in   = w_first ? i_cin : i_k;
            end
            OP_NEG: begin
                if (i_phase_a) begin
                    o_alu_op = OP_NOT;
                end else begin
                    o_sel_t  = 1'b1;
                    o_alu_op = w_first ? OP_INC : OP_PASS;
                    o_c_in   = w_first ? i_cin : i_k;
                end
            end
            default: o_c_in = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_seq8.sv
// alu_seq8: runs a W-bit command as nibble passes through an external 4-bit
// ALU, chaining carry, and returns the wide result with flags.
// Ports: cmd_* (command handshake and operands), alu_* (external ALU
// drive/return), res_* (result handshake, value and flags).
// Optional: define ALU_SEQ_OVF_EN to add the signed-overflow output res_ovf.
module alu_seq8
    import alu_seq_pkg::*;
#(
    parameter  int unsigned NIBBLES = 2,
    localparam int unsigned W       = NIB_W * NIBBLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [W-1:0]     cmd_a,
    input  logic [W-1:0]     cmd_b,
    input  logic             cmd_cin,
    output logic [NIB_W-1:0] alu_A,
    output logic [NIB_W-1:0] alu_B,
    output logic             alu_c_in,
    output logic [2:0]       alu_Op,
    input  logic [NIB_W-1:0] alu_R,
    input  logic             alu_zero,
    input  logic             alu_carry,
    input  logic             alu_sign,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [W-1:0]     res_r,
    output logic             res_zero,
    output logic             res_carry,
    output logic             res_sign
`ifdef ALU_SEQ_OVF_EN
    ,
    output logic             res_ovf
`endif
);

    localparam int unsigned PASS_W = $clog2(2 * NIBBLES + 1);
    localparam int unsigned IDX_W  = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    logic [1:0]        r_state;
    logic [1:0]        w_state_next;
    logic [2:0]        r_op;
    logic [W-1:0]      r_a;
    logic [W-1:0]      r_b;
    logic              r_cin;
    logic              r_k;
    logic [PASS_W-1:0] r_pass;
    logic [W-1:0]      r_acc;
    logic              r_iss_valid;
    logic [IDX_W-1:0]  r_iss_nib;
    logic              r_iss_phase_a;
    logic              r_iss_arith;

    logic              w_neg;
    logic [PASS_W-1:0] w_passes;
    logic              w_last;
    logic [IDX_W-1:0]  w_nib;
    logic              w_phase_a;
    logic              w_k;
    logic [W-1:0]      w_acc_next;
    logic [NIB_W-1:0]  w_a_nib;
    logic [NIB_W-1:0]  w_b_nib;
    logic [2:0]        w_alu_op;
    logic              w_alu_cin;
    logic              w_sel_t;
    logic              w_unused;

    assign w_unused = alu_zero ^ alu_sign;

    // Pass p drives the ALU at one edge; its result is sampled at the next
    assign w_neg     = (r_op == OP_NEG);
    assign w_passes  = w_neg ? PASS_W'(2 * NIBBLES) : PASS_W'(NIBBLES);
    assign w_last    = (r_pass == w_passes);
    assign w_nib     = IDX_W'(w_neg ? (r_pass >> 1) : r_pass);
    assign w_phase_a = w_neg & ~r_pass[0];
    assign w_k       = (r_iss_valid & r_iss_arith) ? alu_carry : r_k;
    assign w_a_nib   = r_a[w_nib * NIB_W +: NIB_W];
    assign w_b_nib   = r_b[w_nib * NIB_W +: NIB_W];

    // Fold the result of the pass in flight into the accumulator
    always_comb begin
        w_acc_next = r_acc;
        if (r_iss_valid && !r_iss_phase_a) begin
            w_acc_next[r_iss_nib * NIB_W +: NIB_W] = alu_R;
        end
    end

`ifdef ALU_SEQ_OVF_EN
    logic w_ovf;
    always_comb begin
        w_ovf = 1'b0;
        case (r_op)
            OP_ADD:          w_ovf = (r_a[W-1] == r_b[W-1]) && (w_acc_next[W-1] != r_a[W-1]);
            OP_PASS, OP_INC: w_ovf = ~r_a[W-1] & w_acc_next[W-1];
            OP_NEG:          w_ovf = r_a[W-1] & w_acc_next[W-1];
            default:         w_ovf = 1'b0;
        endcase
    end
`endif

    alu_seq_opmap #(.IDX_W(IDX_W)) u_opmap (
        .i_op      (r_op),
        .i_nib     (w_nib),
        .i_phase_a (w_phase_a),
        .i_k       (w_k),
        .i_cin     (r_cin),
        .o_alu_op  (w_alu_op),
        .o_c_in    (w_alu_cin),
        .o_sel_t   (w_sel_t)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (cmd_valid) w_state_next = ST_RUN;
            ST_RUN:  if (w_last)    w_state_next = ST_DONE;
            ST_DONE: if (res_ready) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_ready     <= 1'b1;
            res_valid     <= 1'b0;
            res_r         <= '0;
            res_zero      <= 1'b0;
            res_carry     <= 1'b0;
            res_sign      <= 1'b0;
            alu_A         <= '0;
            alu_B         <= '0;
            alu_Op        <= '0;
            alu_c_in      <= 1'b0;
            r_op          <= '0;
            r_a           <= '0;
            r_b           <= '0;
            r_cin         <= 1'b0;
            r_k           <= 1'b0;
            r_pass        <= '0;
            r_acc         <= '0;
            r_iss_valid   <= 1'b0;
            r_iss_nib     <= '0;
            r_iss_phase_a <= 1'b0;
            r_iss_arith   <= 1'b0;
`ifdef ALU_SEQ_OVF_EN
            res_ovf       <= 1'b0;
`endif
        end else begin
            cmd_ready <= (w_state_next == ST_IDLE);
            res_valid <= (w_state_next == ST_DONE);
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_op        <= cmd_op;
                        r_a         <= cmd_a;
                        r_b         <= cmd_b;
                        r_cin       <= cmd_cin;
                        r_k         <= cmd_cin;
                        r_pass      <= '0;
                        r_acc       <= '0;
                        r_iss_valid <= 1'b0;
                    end
                end
                ST_RUN: begin
                    r_acc <= w_acc_next;
                    r_k   <= w_k;
                    if (!w_last) begin
                        // Negate phase b takes t straight from the ALU output
                        alu_A         <= w_sel_t ? alu_R : w_a_nib;
                        alu_B         <= w_b_nib;
                        alu_Op        <= w_alu_op;
                        alu_c_in      <= w_alu_cin;
                        r_iss_valid   <= 1'b1;
                        r_iss_nib     <= w_nib;
                        r_iss_phase_a <= w_phase_a;
                        r_iss_arith   <= is_arith(w_alu_op);
                        r_pass        <= r_pass + PASS_W'(1);
                    end else begin
                        res_r       <= w_acc_next;
                        res_zero    <= (w_acc_next == '0);
                        res_sign    <= w_acc_next[W-1];
                        res_carry   <= is_arith(r_op) ? alu_carry : 1'b0;
                        r_iss_valid <= 1'b0;
`ifdef ALU_SEQ_OVF_EN
                        res_ovf     <= w_ovf;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq8.sv
// tb_alu_seq8: randomized and directed bench for alu_seq8 with a behavioural
// 4-bit ALU attached and a whole-word reference model of each command.
module tb_alu_seq8;

    typedef struct packed {
        logic [7:0] r;
        logic       z;
        logic       c;
        logic       s;
        logic       o;
    } res_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_op = 3'd0;
    logic [7:0] cmd_a = 8'd0;
    logic [7:0] cmd_b = 8'd0;
    logic       cmd_cin = 1'b0;
    logic [3:0] alu_A, alu_B, alu_R;
    logic       alu_c_in, alu_zero, alu_carry, alu_sign;
    logic [2:0] alu_Op;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [7:0] res_r;
    logic       res_zero, res_carry, res_sign;
    logic       ovf_obs;
`ifdef ALU_SEQ_OVF_EN
    logic       res_ovf;
    assign ovf_obs = res_ovf;
`else
    assign ovf_obs = 1'b0;
`endif

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    alu_seq8 #(.NIBBLES(2)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_cin(cmd_cin),
        .alu_A(alu_A), .alu_B(alu_B), .alu_c_in(alu_c_in), .alu_Op(alu_Op),
        .alu_R(alu_R), .alu_zero(alu_zero), .alu_carry(alu_carry), .alu_sign(alu_sign),
        .res_valid(res_valid), .res_ready(res_ready), .res_r(res_r),
        .res_zero(res_zero), .res_carry(res_carry), .res_sign(res_sign)
`ifdef ALU_SEQ_OVF_EN
        , .res_ovf(res_ovf)
`endif
    );

    // Behavioural external 4-bit ALU
    logic [4:0] alu_s;
    always_comb begin
        alu_s = 5'd0;
        case (alu_Op)
            3'b000:  alu_s = {1'b0, alu_A} + {4'd0, alu_c_in};
            3'b001:  alu_s = {1'b0, ~alu_A} + 5'd1 + {4'd0, alu_c_in};
            3'b010:  alu_s = {1'b0, alu_A} + {1'b0, alu_B} + {4'd0, alu_c_in};
            3'b011:  alu_s = {1'b0, alu_A} + 5'd1 + {4'd0, alu_c_in};
            3'b100:  alu_s = {1'b0, alu_A & alu_B};
            3'b101:  alu_s = {1'b0, alu_A | alu_B};
            3'b110:  alu_s = {1'b0, alu_A ^ alu_B};
            default: alu_s = {1'b0, ~alu_A};
        endcase
    end
    assign alu_R     = alu_s[3:0];
    assign alu_carry = alu_s[4];
    assign alu_zero  = (alu_s[3:0] == 4'd0);
    assign alu_sign  = alu_s[3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Whole-word reference: what the command means, independent of nibbles
    function automatic res_t calc(input logic [2:0] op, input logic [7:0] a,
                                  input logic [7:0] b, input logic cin);
        logic [8:0] s;
        res_t x;
        case (op)
            3'd0:    s = {1'b0, a} + 9'(cin);
            3'd1:    s = {1'b0, ~a} + 9'd1 + 9'(cin);
            3'd2:    s = {1'b0, a} + {1'b0, b} + 9'(cin);
            3'd3:    s = {1'b0, a} + 9'd1 + 9'(cin);
            3'd4:    s = {1'b0, a & b};
            3'd5:    s = {1'b0, a | b};
            3'd6:    s = {1'b0, a ^ b};
            default: s = {1'b0, ~a};
        endcase
        x.r = s[7:0];
        x.c = op[2] ? 1'b0 : s[8];
        x.z = (x.r == 8'd0);
        x.s = x.r[7];
        case (op)
            3'd2:       x.o = (a[7] == b[7]) && (x.r[7] != a[7]);
            3'd0, 3'd3: x.o = !a[7] && x.r[7];
            3'd1:       x.o = a[7] && x.r[7];
            default:    x.o = 1'b0;
        endcase
        return x;
    endfunction

    // Handshake model: 0 idle, 1 busy, 2 result offered
    int   m_phase = 0;
    int   m_left = 0;
    res_t m_exp = '0;

    always @(posedge clk) begin
        if (reset) begin
            m_phase <= 0;
        end else begin
            case (m_phase)
                0: if (cmd_valid) begin
                    m_phase <= 1;
                    m_left  <= (cmd_op == 3'd1) ? 4 : 2;
                    m_exp   <= calc(cmd_op, cmd_a, cmd_b, cmd_cin);
                end
                1: if (m_left == 0) m_phase <= 2; else m_left <= m_left - 1;
                default: if (res_ready) m_phase <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("cmd_ready", cmd_ready, m_phase == 0);
            chk("res_valid", res_valid, m_phase == 2);
            if (m_phase == 2) begin
                chk("res_r", res_r, m_exp.r);
                chk("res_zero", res_zero, m_exp.z);
                chk("res_carry", res_carry, m_exp.c);
                chk("res_sign", res_sign, m_exp.s);
`ifdef ALU_SEQ_OVF_EN
                chk("res_ovf", ovf_obs, m_exp.o);
`endif
            end
        end
    end

    task automatic run_cmd(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                           input logic cin, input int hold, input bit pulse,
                           output res_t got, output int lat);
        int n;
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_cin = cin; cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 20) begin @(posedge clk); #1; n++; end
        chk("accept_bound", n < 20, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        lat = 0;
        while (!res_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        chk("result_bound", lat < 20, 1);
        got.r = res_r; got.z = res_zero; got.c = res_carry; got.s = res_sign; got.o = ovf_obs;
        for (int h = 0; h < hold; h++) begin
            if (pulse && h == 0) begin
                cmd_valid = 1'b1; cmd_op = 3'd2; cmd_a = 8'h77; cmd_b = 8'h11;
            end
            if (pulse) chk("hold_cmd_ready", cmd_ready, 0);
            @(posedge clk); #1;
            cmd_valid = 1'b0;
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    res_t got;
    int   lat;

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_r", res_r, 0);
        chk("rst_flags", {res_zero, res_carry, res_sign, ovf_obs}, 0);
        chk("rst_alu", {alu_A, alu_B, alu_Op, alu_c_in}, 0);

        run_cmd(3'd2, 8'h3C, 8'h4F, 1'b0, 0, 1'b0, got, lat);
        chk("add_r", got.r, 8'h8B);
        chk("add_flags", {got.z, got.c, got.s}, 3'b001);
        chk("add_lat", lat, 3);
`ifdef ALU_SEQ_OVF_EN
        chk("add_ovf", got.o, 1);
`endif

        run_cmd(3'd3, 8'hFF, 8'h00, 1'b0, 0, 1'b0, got, lat);
        chk("inc_r", got.r, 8'h00);
        chk("inc_flags", {got.z, got.c, got.s}, 3'b110);

        run_cmd(3'd1, 8'h03, 8'h00, 1'b0, 0, 1'b0, got, lat);
        chk("neg3_r", got.r, 8'hFD);
        chk("neg3_flags", {got.z, got.c, got.s}, 3'b001);
        chk("neg3_lat", lat, 5);

        run_cmd(3'd1, 8'h00, 8'h00, 1'b0, 0, 1'b0, got, lat);
        chk("neg0_r", got.r, 8'h00);
        chk("neg0_flags", {got.z, got.c}, 2'b11);
        chk("neg0_lat", lat, 5);

        run_cmd(3'd4, 8'hA5, 8'h3C, 1'b1, 0, 1'b0, got, lat);
        chk("and_r", got.r, 8'h24);
        chk("and_carry", got.c, 0);

        run_cmd(3'd7, 8'hA5, 8'h00, 1'b1, 0, 1'b0, got, lat);
        chk("not_r", got.r, 8'h5A);
        chk("not_sign", got.s, 0);

        // Backpressure with a stray command pulse during DONE
        run_cmd(3'd2, 8'h12, 8'h34, 1'b0, 3, 1'b1, got, lat);
        chk("bp_r", got.r, 8'h46);
        chk("bp_ready_after", cmd_ready, 1);
        @(posedge clk); #1;
        chk("bp_no_accept_valid", res_valid, 0);
        chk("bp_no_accept_ready", cmd_ready, 1);

        // Reset in the middle of a negate
        cmd_op = 3'd1; cmd_a = 8'h5A; cmd_cin = 1'b0; cmd_valid = 1'b1;
        @(posedge clk); #1 cmd_valid = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        chk("mid_rst_ready", cmd_ready, 1);
        chk("mid_rst_valid", res_valid, 0);
        chk("mid_rst_op", alu_Op, 0);
        chk("mid_rst_r", res_r, 0);
        run_cmd(3'd2, 8'h01, 8'h01, 1'b0, 0, 1'b0, got, lat);
        chk("post_rst_add", got.r, 8'h02);

        for (int i = 0; i < 150; i++) begin
            run_cmd(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 1'($urandom),
                    int'($urandom_range(0, 3)), 1'b0, got, lat);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end

        repeat (3) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
